// File: rtl/nvme_errlog_ctl_pkg.sv
// ---------------------------------------------------------------------------
// nvme_errlog_ctl_pkg
// Shared definitions for the NVMe error/event log controller and its helpers:
//   - ZERO            : single-bit zero constant
//   - errlog_state_e  : report handshake FSM encodings
//   - clog2()         : ceiling log2 for parameter checks
//   - popcount()      : population count over a vector of up to POPCNT_MAX bits
// ---------------------------------------------------------------------------
package nvme_errlog_ctl_pkg;

    localparam logic ZERO       = 1'b0;
    localparam int   POPCNT_MAX = 128;

    typedef enum logic [0:0] {
        ERRLOG_IDLE    = 1'b0,
        ERRLOG_PRESENT = 1'b1
    } errlog_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Callers zero-extend narrower vectors to POPCNT_MAX bits.
    function automatic logic [7:0] popcount(input logic [POPCNT_MAX-1:0] v);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < POPCNT_MAX; i++) c = c + {7'd0, v[i]};
        return c;
    endfunction

endpackage

// File: rtl/nvme_rr_pick.sv
// ---------------------------------------------------------------------------
// nvme_rr_pick
// Combinational round-robin priority picker. Grants the lowest requesting
// index at or above ptr; if none, wraps and grants the lowest requester
// overall. With ptr = 0 it degenerates to a plain lowest-set-bit finder.
// Ports:
//   req       in  width      request vector
//   ptr       in  idx_width  search start position
//   gnt_valid out 1          any request present
//   gnt_idx   out idx_width  granted index (0 when gnt_valid = 0)
// ---------------------------------------------------------------------------
module nvme_rr_pick #(
    parameter int width     = 32,
    parameter int idx_width = 5
) (
    input  logic [width-1:0]     req,
    input  logic [idx_width-1:0] ptr,
    output logic                 gnt_valid,
    output logic [idx_width-1:0] gnt_idx
);

    logic                 hi_valid;
    logic [idx_width-1:0] hi_idx;
    logic                 lo_valid;
    logic [idx_width-1:0] lo_idx;

    // Scan from the top down so the last hit is the lowest index in each set.
    always_comb begin
        hi_valid = 1'b0;
        hi_idx   = '0;
        lo_valid = 1'b0;
        lo_idx   = '0;
        for (int i = width - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_valid = 1'b1;
                lo_idx   = idx_width'(i);
                if (i >= int'(ptr)) begin
                    hi_valid = 1'b1;
                    hi_idx   = idx_width'(i);
                end
            end
        end
        gnt_valid = lo_valid;
        gnt_idx   = hi_valid ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/nvme_errlog_ctl.sv
// ---------------------------------------------------------------------------
// nvme_errlog_ctl
// Bank of sticky error/event bits with first-error capture and a
// one-at-a-time round-robin reporting handshake.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   event_in   in  W    per-source set request (sets the sticky bit)
//   mask       in  W    1 = latch but never report
//   clr_valid  in  1    qualifies clr_mask
//   clr_mask   in  W    write-1-to-clear of sticky bits
//   sticky_out out W    sticky status
//   first_valid/first_idx  out  first-error capture
//   rpt_valid/rpt_idx out, rpt_ack in   report handshake
//   pending_cnt out I+1 count of eligible, unreported bits (one cycle lag)
// ---------------------------------------------------------------------------
module nvme_errlog_ctl
    import nvme_errlog_ctl_pkg::*;
#(
    parameter int width     = 32,
    parameter int idx_width = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [width-1:0]     event_in,
    input  logic [width-1:0]     mask,
    input  logic                 clr_valid,
    input  logic [width-1:0]     clr_mask,
    output logic [width-1:0]     sticky_out,
    output logic                 first_valid,
    output logic [idx_width-1:0] first_idx,
    output logic                 rpt_valid,
    output logic [idx_width-1:0] rpt_idx,
    input  logic                 rpt_ack,
    output logic [idx_width:0]   pending_cnt
);

    if (idx_width < clog2(width) || width < 2 || width > POPCNT_MAX) begin : g_bad_params
        $error("nvme_errlog_ctl: invalid width/idx_width");
    end

    errlog_state_e        state_q, state_d;
    logic [width-1:0]     sticky_q, sticky_d;
    logic [width-1:0]     reported_q, reported_d;
    logic                 first_valid_q, first_valid_d;
    logic [idx_width-1:0] first_idx_q, first_idx_d;
    logic [idx_width-1:0] rpt_idx_q, rpt_idx_d;
    logic [idx_width-1:0] ptr_q, ptr_d;
    logic [idx_width:0]   pending_q, pending_d;

    logic [width-1:0]     clr_vec;
    logic [width-1:0]     ack_vec;
    logic [width-1:0]     eligible;
    logic                 ack_fire;
    logic                 pick_valid;
    logic [idx_width-1:0] pick_idx;
    logic                 ev_any;
    logic [idx_width-1:0] ev_low_idx;

    assign clr_vec  = {width{clr_valid}} & clr_mask;
    assign ack_fire = (state_q == ERRLOG_PRESENT) && rpt_ack;
    assign eligible = sticky_q & ~mask & ~reported_q;

    always_comb begin
        ack_vec = '0;
        if (ack_fire) ack_vec[rpt_idx_q] = 1'b1;
    end

    // Set wins over a same-cycle clear.
    assign sticky_d = event_in | (sticky_q & ~clr_vec);
    // Masking with sticky_d makes a clear win over a same-cycle ack, and keeps
    // an ack on an already-cleared bit from marking it reported.
    assign reported_d = (reported_q | ack_vec) & sticky_d;

    assign pending_d = (idx_width + 1)'(popcount(POPCNT_MAX'(eligible)));

    nvme_rr_pick #(.width(width), .idx_width(idx_width)) u_rr (
        .req       (eligible),
        .ptr       (ptr_q),
        .gnt_valid (pick_valid),
        .gnt_idx   (pick_idx)
    );

    // Lowest set bit of event_in for first-error capture.
    nvme_rr_pick #(.width(width), .idx_width(idx_width)) u_first (
        .req       (event_in),
        .ptr       ({idx_width{ZERO}}),
        .gnt_valid (ev_any),
        .gnt_idx   (ev_low_idx)
    );

    // While any sticky bit is set the capture is frozen. Once the bank is
    // empty, the flag follows event_in: capture, re-capture, or drop.
    always_comb begin
        first_valid_d = first_valid_q;
        first_idx_d   = first_idx_q;
        if (sticky_q == '0) begin
            first_valid_d = ev_any;
            if (ev_any) first_idx_d = ev_low_idx;
        end
    end

    always_comb begin
        state_d   = state_q;
        rpt_idx_d = rpt_idx_q;
        ptr_d     = ptr_q;
        unique case (state_q)
            ERRLOG_IDLE: begin
                if (pick_valid) begin
                    rpt_idx_d = pick_idx;
                    state_d   = ERRLOG_PRESENT;
                end
            end
            ERRLOG_PRESENT: begin
                if (rpt_ack) begin
                    ptr_d   = (rpt_idx_q == idx_width'(width - 1)) ? '0 : rpt_idx_q + 1'b1;
                    state_d = ERRLOG_IDLE;
                end
            end
            default: state_d = ERRLOG_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ERRLOG_IDLE;
            sticky_q      <= '0;
            reported_q    <= '0;
            first_valid_q <= 1'b0;
            first_idx_q   <= '0;
            rpt_idx_q     <= '0;
            ptr_q         <= '0;
            pending_q     <= '0;
        end else begin
            state_q       <= state_d;
            sticky_q      <= sticky_d;
            reported_q    <= reported_d;
            first_valid_q <= first_valid_d;
            first_idx_q   <= first_idx_d;
            rpt_idx_q     <= rpt_idx_d;
            ptr_q         <= ptr_d;
            pending_q     <= pending_d;
        end
    end

    assign sticky_out  = sticky_q;
    assign first_valid = first_valid_q;
    assign first_idx   = first_idx_q;
    assign rpt_valid   = (state_q == ERRLOG_PRESENT);
    assign rpt_idx     = rpt_idx_q;
    assign pending_cnt = pending_q;

endmodule

// File: tb/tb_nvme_errlog_ctl.sv
module tb_nvme_errlog_ctl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] event_in = '0;
    logic [31:0] mask = '0;
    logic        clr_valid = 1'b0;
    logic [31:0] clr_mask = '0;
    logic [31:0] sticky_out;
    logic        first_valid;
    logic [4:0]  first_idx;
    logic        rpt_valid;
    logic [4:0]  rpt_idx;
    logic        rpt_ack = 1'b0;
    logic [5:0]  pending_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nvme_errlog_ctl #(.width(32), .idx_width(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .event_in    (event_in),
        .mask        (mask),
        .clr_valid   (clr_valid),
        .clr_mask    (clr_mask),
        .sticky_out  (sticky_out),
        .first_valid (first_valid),
        .first_idx   (first_idx),
        .rpt_valid   (rpt_valid),
        .rpt_idx     (rpt_idx),
        .rpt_ack     (rpt_ack),
        .pending_cnt (pending_cnt)
    );

    // Advance one edge; inputs are driven and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        event_in = '0; mask = '0; clr_valid = 1'b0; clr_mask = '0; rpt_ack = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (sticky_out !== 32'h0 || first_valid !== 1'b0 || first_idx !== 5'd0 ||
            rpt_valid !== 1'b0 || rpt_idx !== 5'd0 || pending_cnt !== 6'd0) begin
            n_err++;
            $display("FAIL reset_state got sticky=%h fv=%b fi=%0d rv=%b ri=%0d pc=%0d required all zero",
                     sticky_out, first_valid, first_idx, rpt_valid, rpt_idx, pending_cnt);
        end
    endtask

    task automatic test_single_event();
        bit rerep;
        do_reset();
        event_in = 32'h4;
        tick();
        event_in = '0;
        n_cmp++;
        if (sticky_out !== 32'h4 || first_valid !== 1'b1 || first_idx !== 5'd2 || rpt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_n1 got sticky=%h fv=%b fi=%0d rv=%b required 4 1 2 0",
                     sticky_out, first_valid, first_idx, rpt_valid);
        end
        tick();
        n_cmp++;
        if (rpt_valid !== 1'b1 || rpt_idx !== 5'd2 || pending_cnt !== 6'd1) begin
            n_err++;
            $display("FAIL single_n2 got rv=%b ri=%0d pc=%0d required 1 2 1", rpt_valid, rpt_idx, pending_cnt);
        end
        rpt_ack = 1'b1;
        tick();
        rpt_ack = 1'b0;
        n_cmp++;
        if (rpt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_ackdrop got rv=%b required 0", rpt_valid);
        end
        tick();
        n_cmp++;
        if (pending_cnt !== 6'd0) begin
            n_err++;
            $display("FAIL single_pending got %0d required 0", pending_cnt);
        end
        rerep = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rpt_valid !== 1'b0) rerep = 1'b1;
        end
        n_cmp++;
        if (rerep !== 1'b0 || sticky_out !== 32'h4) begin
            n_err++;
            $display("FAIL single_no_rereport got rerep=%b sticky=%h required 0 00000004", rerep, sticky_out);
        end
    endtask

    task automatic test_rr_order();
        do_reset();
        event_in = 32'h0000_0A00;
        tick();
        event_in = '0;
        n_cmp++;
        if (first_idx !== 5'd9 || first_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rr_first got fi=%0d fv=%b required 9 1", first_idx, first_valid);
        end
        tick();
        n_cmp++;
        if (rpt_valid !== 1'b1 || rpt_idx !== 5'd9 || pending_cnt !== 6'd2) begin
            n_err++;
            $display("FAIL rr_rep9 got rv=%b ri=%0d pc=%0d required 1 9 2", rpt_valid, rpt_idx, pending_cnt);
        end
        rpt_ack = 1'b1;
        tick();
        rpt_ack = 1'b0;
        n_cmp++;
        if (rpt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rr_gap got rv=%b required 0", rpt_valid);
        end
        tick();
        n_cmp++;
        if (rpt_valid !== 1'b1 || rpt_idx !== 5'd11) begin
            n_err++;
            $display("FAIL rr_rep11 got rv=%b ri=%0d required 1 11", rpt_valid, rpt_idx);
        end
        rpt_ack = 1'b1;
        tick();
        rpt_ack = 1'b0;
        // ptr is now 12: with bits 0 and 13 both new, 13 goes first.
        clr_valid = 1'b1; clr_mask = 32'hFFFF_FFFF;
        tick();
        clr_valid = 1'b0; clr_mask = '0;
        event_in = 32'h0000_2001;
        tick();
        event_in = '0;
        tick();
        n_cmp++;
        if (rpt_valid !== 1'b1 || rpt_idx !== 5'd13) begin
            n_err++;
            $display("FAIL rr_ptr12 got rv=%b ri=%0d required 1 13", rpt_valid, rpt_idx);
        end
        rpt_ack = 1'b1;
        tick();
        rpt_ack = 1'b0;
        tick();
        n_cmp++;
        if (rpt_valid !== 1'b1 || rpt_idx !== 5'd0) begin
            n_err++;
            $display("FAIL rr_wrap0 got rv=%b ri=%0d required 1 0", rpt_valid, rpt_idx);
        end
    endtask

    task automatic test_mask();
        bit leaked;
        do_reset();
        mask = 32'h1;
        event_in = 32'h1;
        tick();
        event_in = '0;
        n_cmp++;
        if (sticky_out !== 32'h1 || first_valid !== 1'b1 || first_idx !== 5'd0) begin
            n_err++;
            $display("FAIL mask_latch got sticky=%h fv=%b fi=%0d required 1 1 0", sticky_out, first_valid, first_idx);
        end
        leaked = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rpt_valid !== 1'b0 || pending_cnt !== 6'd0) leaked = 1'b1;
        end
        n_cmp++;
        if (leaked !== 1'b0) begin
            n_err++;
            $display("FAIL mask_hold got leaked=%b required 0", leaked);
        end
        mask = '0;
        tick();
        n_cmp++;
        if (rpt_valid !== 1'b1 || rpt_idx !== 5'd0 || pending_cnt !== 6'd1) begin
            n_err++;
            $display("FAIL mask_release got rv=%b ri=%0d pc=%0d required 1 0 1", rpt_valid, rpt_idx, pending_cnt);
        end
        rpt_ack = 1'b1;
        tick();
        rpt_ack = 1'b0;
    endtask

    task automatic test_set_clear();
        do_reset();
        clr_valid = 1'b1; clr_mask = 32'h4; event_in = 32'h4;
        tick();
        clr_valid = 1'b0; clr_mask = '0; event_in = '0;
        n_cmp++;
        if (sticky_out !== 32'h4) begin
            n_err++;
            $display("FAIL setclr_setwins got %h required 00000004", sticky_out);
        end
        clr_valid = 1'b1; clr_mask = 32'h4;
        tick();
        clr_valid = 1'b0; clr_mask = '0;
        n_cmp++;
        if (sticky_out !== 32'h0) begin
            n_err++;
            $display("FAIL setclr_clear got %h required 00000000", sticky_out);
        end
        tick();
        n_cmp++;
        if (first_valid !== 1'b0) begin
            n_err++;
            $display("FAIL setclr_fv_drop got %b required 0", first_valid);
        end
        event_in = 32'h30;
        tick();
        event_in = '0;
        n_cmp++;
        if (first_valid !== 1'b1 || first_idx !== 5'd4) begin
            n_err++;
            $display("FAIL setclr_recapture got fv=%b fi=%0d required 1 4", first_valid, first_idx);
        end
        event_in = 32'h1;
        tick();
        event_in = '0;
        n_cmp++;
        if (first_idx !== 5'd4 || sticky_out !== 32'h31) begin
            n_err++;
            $display("FAIL setclr_fi_hold got fi=%0d sticky=%h required 4 00000031", first_idx, sticky_out);
        end
    endtask

    task automatic test_clear_under_present();
        bit moved;
        do_reset();
        event_in = 32'h20;
        tick();
        event_in = '0;
        tick();
        clr_valid = 1'b1; clr_mask = 32'h20;
        tick();
        clr_valid = 1'b0; clr_mask = '0;
        moved = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rpt_valid !== 1'b1 || rpt_idx !== 5'd5) moved = 1'b1;
            tick();
        end
        n_cmp++;
        if (moved !== 1'b0 || sticky_out !== 32'h0) begin
            n_err++;
            $display("FAIL cup_stable got moved=%b sticky=%h required 0 00000000", moved, sticky_out);
        end
        rpt_ack = 1'b1;
        tick();
        rpt_ack = 1'b0;
        tick();
        n_cmp++;
        if (rpt_valid !== 1'b0 || pending_cnt !== 6'd0) begin
            n_err++;
            $display("FAIL cup_after_ack got rv=%b pc=%0d required 0 0", rpt_valid, pending_cnt);
        end
        event_in = 32'h20;
        tick();
        event_in = '0;
        tick();
        n_cmp++;
        if (rpt_valid !== 1'b1 || rpt_idx !== 5'd5) begin
            n_err++;
            $display("FAIL cup_rereport got rv=%b ri=%0d required 1 5", rpt_valid, rpt_idx);
        end
        rpt_ack = 1'b1;
        tick();
        rpt_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2:0] seen;
        logic [4:0] idx_a;
        logic [4:0] idx_b;
        do_reset();
        event_in = 32'h3;
        tick();
        event_in = '0;
        rpt_ack = 1'b1;
        idx_a = '0; idx_b = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen[i] = rpt_valid;
            if (i == 0) idx_a = rpt_idx;
            if (i == 2) idx_b = rpt_idx;
        end
        rpt_ack = 1'b0;
        n_cmp++;
        if (seen !== 3'b101 || idx_a !== 5'd0 || idx_b !== 5'd1) begin
            n_err++;
            $display("FAIL b2b got seen=%b a=%0d b=%0d required 101 0 1", seen, idx_a, idx_b);
        end
    endtask

    task automatic test_reset_mid_present();
        bit spur;
        do_reset();
        event_in = 32'h80;
        tick();
        event_in = '0;
        tick();
        rpt_ack = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (rpt_valid !== 1'b0 || rpt_idx !== 5'd0 || sticky_out !== 32'h0 ||
            first_valid !== 1'b0 || pending_cnt !== 6'd0) begin
            n_err++;
            $display("FAIL rstmid_async got rv=%b ri=%0d sticky=%h fv=%b pc=%0d required all zero",
                     rpt_valid, rpt_idx, sticky_out, first_valid, pending_cnt);
        end
        tick();
        reset = 1'b0;
        rpt_ack = 1'b0;
        spur = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rpt_valid !== 1'b0) spur = 1'b1;
        end
        n_cmp++;
        if (spur !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_quiet got spur=%b required 0", spur);
        end
        event_in = 32'h80;
        tick();
        event_in = '0;
        tick();
        n_cmp++;
        if (rpt_valid !== 1'b1 || rpt_idx !== 5'd7) begin
            n_err++;
            $display("FAIL rstmid_new got rv=%b ri=%0d required 1 7", rpt_valid, rpt_idx);
        end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_rr_order();
        test_mask();
        test_set_clear();
        test_clear_under_present();
        test_back_to_back();
        test_reset_mid_present();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
